// File: rtl/rate_spike_encoder.sv
// Rate-coding spike encoder: one intensity sample becomes a WINDOW-cycle binary spike train.
// Define RATE_SPIKE_ENC_STOCHASTIC_EN for LFSR Bernoulli coding instead of the phase accumulator.
module rate_spike_encoder #(
    parameter int          DATA_W = 8,
    parameter int          WINDOW = 16,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         spike_out,
    output logic                         busy,
    output logic                         window_done,
    output logic [$clog2(WINDOW+1)-1:0]  spike_count
);

    localparam int SC_W  = $clog2(WINDOW + 1);
    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ENCODE = 1'b1;

    logic [0:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] value_reg;
    logic              spike_reg;
    logic              done_reg;
    logic [SC_W-1:0]   count_reg;
    logic              step_spike;

`ifdef RATE_SPIKE_ENC_STOCHASTIC_EN
    // Galois form of x^16+x^14+x^13+x^11+1; a zero seed would lock the LFSR up.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    always_comb begin
        lfsr_next  = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
        step_spike = (lfsr_reg[DATA_W-1:0] < value_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= SEED_EFF;
        end else if (state_reg == ST_ENCODE) begin
            lfsr_reg <= lfsr_next;
        end
    end
`else
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W:0]   sum_next;

    // The carry out of the phase accumulator is the spike.
    always_comb begin
        sum_next   = {1'b0, acc_reg} + {1'b0, value_reg};
        step_spike = sum_next[DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            if (in_valid) begin
                acc_reg <= '0;
            end
        end else begin
            acc_reg <= sum_next[DATA_W-1:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            value_reg <= '0;
            spike_reg <= 1'b0;
            done_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                spike_reg <= 1'b0;
                if (in_valid) begin
                    value_reg <= in_data;
                    cnt_reg   <= '0;
                    count_reg <= '0;
                    state_reg <= ST_ENCODE;
                end
            end else begin
                spike_reg <= step_spike;
                if (step_spike) begin
                    count_reg <= count_reg + SC_W'(1);
                end
                if (cnt_reg == CNT_LAST) begin
                    cnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready    = (state_reg == ST_IDLE);
    assign busy        = (state_reg == ST_ENCODE);
    assign spike_out   = spike_reg;
    assign window_done = done_reg;
    assign spike_count = count_reg;

endmodule

// File: tb/tb_rate_spike_encoder.sv
// Directed and randomised bench for rate_spike_encoder (deterministic build, DATA_W=8, WINDOW=16).
module tb_rate_spike_encoder;

    localparam int DW  = 8;
    localparam int W   = 16;
    localparam int SCW = $clog2(W + 1);

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           in_ready;
    logic           spike_out;
    logic           busy;
    logic           window_done;
    logic [SCW-1:0] spike_count;

    int n_cmp = 0;
    int n_bad = 0;

    rate_spike_encoder #(
        .DATA_W (DW),
        .WINDOW (W),
        .SEED   (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .spike_out   (spike_out),
        .busy        (busy),
        .window_done (window_done),
        .spike_count (spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === 32'(exp)) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ideal rate coder: spikes emitted in the first i steps = floor(v*i / 2^DW).
    function automatic int spikes_upto(input int v, input int i);
        return (v * i) / (1 << DW);
    endfunction

    // Entered just after an edge with the block idle; returns just after the last window edge.
    task automatic run_window(input int v, input bit keep_valid);
        int exp_spike;
        chk("ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = DW'(v);
        @(posedge clk); #1;
        in_data = DW'($urandom);
        if (!keep_valid) in_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", in_ready, 0);
        chk("spike_after_accept", spike_out, 0);
        chk("count_after_accept", spike_count, 0);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            exp_spike = spikes_upto(v, i) - spikes_upto(v, i - 1);
            chk($sformatf("spike v=%0d step=%0d", v, i), spike_out, exp_spike);
            chk($sformatf("count v=%0d step=%0d", v, i), spike_count, spikes_upto(v, i));
            if (i < W) begin
                chk($sformatf("done_early v=%0d step=%0d", v, i), window_done, 0);
                chk($sformatf("ready_low v=%0d step=%0d", v, i), in_ready, 0);
            end else begin
                chk($sformatf("done_pulse v=%0d", v), window_done, 1);
                chk($sformatf("ready_back v=%0d", v), in_ready, 1);
                chk($sformatf("busy_clear v=%0d", v), busy, 0);
            end
        end
        $display("window value=%0d spike_count=%0d expected=%0d", v, spike_count, spikes_upto(v, W));
    endtask

    // One idle cycle: spike low, pulse gone, final count held.
    task automatic post_idle(input int v);
        in_data = DW'($urandom);
        @(posedge clk); #1;
        chk("idle_done_low", window_done, 0);
        chk("idle_spike_low", spike_out, 0);
        chk("idle_ready", in_ready, 1);
        chk("idle_count_hold", spike_count, spikes_upto(v, W));
    endtask

    initial begin
        int v;
        int gap;
        bit keep;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_spike", spike_out, 0);
        chk("rst_done", window_done, 0);
        chk("rst_count", spike_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // value 0, 128 and 255 windows
        run_window(0, 1'b0);   post_idle(0);
        run_window(128, 1'b0); post_idle(128);
        run_window(255, 1'b0); post_idle(255);

        // reset in the middle of a value=200 window
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midwin_spike", spike_out, spikes_upto(200, 4) - spikes_upto(200, 3));
        chk("midwin_count", spike_count, spikes_upto(200, 4));
        rst_n = 1'b0;
        #1;
        chk("abort_spike", spike_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_count", spike_count, 0);
        chk("abort_done", window_done, 0);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk("abort_no_done", window_done, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_window(200, 1'b0); post_idle(200);

        // in_valid held high across back-to-back windows
        run_window(64, 1'b1);
        run_window(192, 1'b1);
        run_window(0, 1'b1);
        in_valid = 1'b0;
        post_idle(0);

        // random values, random back-to-back or idle gaps
        for (int n = 0; n < 24; n++) begin
            v    = $urandom_range(0, 255);
            keep = 1'($urandom_range(0, 1));
            run_window(v, keep);
            if (!keep) begin
                gap = $urandom_range(1, 3);
                for (int j = 0; j < gap; j++) post_idle(v);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
